pe_input_feeder: RTL



---
 rtl/pe_input_feeder_pkg.sv | 20 ++
 rtl/pe_input_feeder_if.sv | 58 +++++
 rtl/pe_input_feeder_stage.sv | 58 +++++
 rtl/pe_input_feeder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pe_input_feeder_pkg.sv
// Shared types and defaults for the PE input feeder.
// Holds the FSM encoding and the IFMap flag bit positions.
package pe_pkg;

  localparam int DEF_IFMAP_WIDTH  = 18;
  localparam int DEF_FILTER_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_FSR_SIZE     = 8;

  localparam int SOR_BIT = DEF_IFMAP_WIDTH - 1;
  localparam int EOR_BIT = DEF_IFMAP_WIDTH - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILTER,
    S_IFMAP,
    S_FINISH
  } state_e;

endpackage

// File: rtl/pe_input_feeder_if.sv
// Feeder bus: job control, source memory ports and PE FIFO ports.
// master = feeder side, slave = environment side.
interface pe_input_feeder_if
  import pe_pkg::*;
#(
  parameter int IFMAP_WIDTH          = DEF_IFMAP_WIDTH,
  parameter int FILTER_WIDTH         = DEF_FILTER_WIDTH,
  parameter int ADDR_WIDTH           = DEF_ADDR_WIDTH,
  parameter int FILTER_SIZE_REG_SIZE = DEF_FSR_SIZE
) ();

  logic                            start;
  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size;
  logic [FILTER_SIZE_REG_SIZE-1:0] row_len;
  logic [FILTER_SIZE_REG_SIZE-1:0] num_rows;
  logic [ADDR_WIDTH-1:0]           filt_base;
  logic [ADDR_WIDTH-1:0]           if_base;

  logic                            filt_rd_en;
  logic [ADDR_WIDTH-1:0]           filt_addr;
  logic [FILTER_WIDTH-1:0]         filt_rd_data;
  logic                            if_rd_en;
  logic [ADDR_WIDTH-1:0]           if_addr;
  logic [IFMAP_WIDTH-3:0]          if_rd_data;

  logic                            filter_wen;
  logic [FILTER_WIDTH-1:0]         filter_dout;
  logic                            filter_full;
  logic                            ifmap_wen;
  logic [IFMAP_WIDTH-1:0]          ifmap_dout;
  logic                            ifmap_full;

  logic                            busy;
  logic                            done;

  modport master (
    input  start, filter_size, row_len, num_rows,
    input  filt_base, if_base,
    input  filt_rd_data, if_rd_data,
    input  filter_full, ifmap_full,
    output filt_rd_en, filt_addr, if_rd_en, if_addr,
    output filter_wen, filter_dout,
    output ifmap_wen, ifmap_dout,
    output busy, done
  );

  modport slave (
    output start, filter_size, row_len, num_rows,
    output filt_base, if_base,
    output filt_rd_data, if_rd_data,
    output filter_full, ifmap_full,
    input  filt_rd_en, filt_addr, if_rd_en, if_addr,
    input  filter_wen, filter_dout,
    input  ifmap_wen, ifmap_dout,
    input  busy, done
  );

endinterface

// File: rtl/pe_input_feeder_stage.sv
// Two-entry staging buffer between a 1-cycle-latency memory
// and a PE FIFO, with in-flight read accounting.
module feeder_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         more_i,
  input  logic         full_i,
  input  logic [W-1:0] rd_data_i,
  output logic         rd_en_o,
  output logic         wen_o,
  output logic         valid_o,
  output logic [W-1:0] dout_o,
  output logic         drain_o
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] buf0_q, buf0_d;
  logic [W-1:0] buf1_q, buf1_d;
  logic         infl_q;
  logic         pop, push;

  // Returning data may bypass an empty buffer straight to the FIFO.
  always_comb begin
    valid_o = (cnt_q != 2'd0) || infl_q;
    dout_o  = (cnt_q != 2'd0) ? buf0_q : rd_data_i;
    wen_o   = valid_o && !full_i;
    rd_en_o = more_i &&
              (({1'b0, cnt_q} + {2'b0, infl_q}) < 3'd2);
    pop     = wen_o && (cnt_q != 2'd0);
    push    = infl_q && !(wen_o && (cnt_q == 2'd0));
    buf0_d  = pop ? buf1_q : buf0_q;
    buf1_d  = buf1_q;
    cnt_d   = cnt_q - {1'b0, pop};
    if (push) begin
      if (cnt_d == 2'd0) buf0_d = rd_data_i;
      else               buf1_d = rd_data_i;
      cnt_d = cnt_d + 2'd1;
    end
    drain_o = (cnt_d == 2'd0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      buf0_q <= '0;
      buf1_q <= '0;
      infl_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      infl_q <= rd_en_o;
    end
  end

endmodule

// File: rtl/pe_input_feeder.sv
// Streams a filter block then row-flagged IFMap words from
// source memories into the PE FIFOs.
module pe_input_feeder
  import pe_pkg::*;
#(
  parameter int IFMAP_WIDTH          = DEF_IFMAP_WIDTH,
  parameter int FILTER_WIDTH         = DEF_FILTER_WIDTH,
  parameter int ADDR_WIDTH           = DEF_ADDR_WIDTH,
  parameter int FILTER_SIZE_REG_SIZE = DEF_FSR_SIZE
) (
  input logic              clk,
  input logic              rstn,
  pe_input_feeder_if.master bus
);

  localparam int DW  = IFMAP_WIDTH - 2;
  localparam int FS  = FILTER_SIZE_REG_SIZE;
  localparam int SOR = SOR_BIT + IFMAP_WIDTH - DEF_IFMAP_WIDTH;
  localparam int EOR = EOR_BIT + IFMAP_WIDTH - DEF_IFMAP_WIDTH;

  state_e                  state_q;
  logic                    busy_q, done_q;
  logic [FS-1:0]           rlen_q, nrows_q, frem_q;
  logic [FS-1:0]           icol_q, irow_q, wcol_q;
  logic [ADDR_WIDTH-1:0]   faddr_q, iaddr_q;

  logic                    f_more, f_rd, f_wen, f_valid, f_drain;
  logic [FILTER_WIDTH-1:0] f_dout;
  logic                    i_more, i_rd, i_wen, i_valid, i_drain;
  logic [DW-1:0]           i_dout;
  logic                    f_end, i_end, no_ifmap;
  logic [IFMAP_WIDTH-1:0]  iword;

  assign f_more   = (state_q == S_FILTER) && (frem_q != '0);
  assign i_more   = (state_q == S_IFMAP) && (irow_q != nrows_q);
  assign f_end    = (frem_q == '0) && f_drain;
  assign i_end    = (irow_q == nrows_q) && i_drain;
  assign no_ifmap = (rlen_q == '0) || (nrows_q == '0);

  feeder_stage #(.W(FILTER_WIDTH)) u_filt (
    .clk       (clk),
    .rstn      (rstn),
    .more_i    (f_more),
    .full_i    (bus.filter_full),
    .rd_data_i (bus.filt_rd_data),
    .rd_en_o   (f_rd),
    .wen_o     (f_wen),
    .valid_o   (f_valid),
    .dout_o    (f_dout),
    .drain_o   (f_drain)
  );

  feeder_stage #(.W(DW)) u_ifm (
    .clk       (clk),
    .rstn      (rstn),
    .more_i    (i_more),
    .full_i    (bus.ifmap_full),
    .rd_data_i (bus.if_rd_data),
    .rd_en_o   (i_rd),
    .wen_o     (i_wen),
    .valid_o   (i_valid),
    .dout_o    (i_dout),
    .drain_o   (i_drain)
  );

  // Row flags follow the write position, which is always in order.
  always_comb begin
    iword = '0;
    if (i_valid) begin
      iword[DW-1:0] = i_dout;
      iword[SOR]    = (wcol_q == '0);
      iword[EOR]    = (wcol_q == rlen_q - FS'(1));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rlen_q  <= '0;
      nrows_q <= '0;
      frem_q  <= '0;
      icol_q  <= '0;
      irow_q  <= '0;
      wcol_q  <= '0;
      faddr_q <= '0;
      iaddr_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (f_rd) begin
        faddr_q <= faddr_q + ADDR_WIDTH'(1);
        frem_q  <= frem_q - FS'(1);
      end
      if (i_rd) begin
        iaddr_q <= iaddr_q + ADDR_WIDTH'(1);
        if (icol_q == rlen_q - FS'(1)) begin
          icol_q <= '0;
          irow_q <= irow_q + FS'(1);
        end else begin
          icol_q <= icol_q + FS'(1);
        end
      end
      if (i_wen) begin
        wcol_q <= (wcol_q == rlen_q - FS'(1)) ?
                  '0 : wcol_q + FS'(1);
      end
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q  <= 1'b1;
            rlen_q  <= bus.row_len;
            nrows_q <= bus.num_rows;
            frem_q  <= bus.filter_size;
            faddr_q <= bus.filt_base;
            iaddr_q <= bus.if_base;
            icol_q  <= '0;
            irow_q  <= '0;
            wcol_q  <= '0;
            if (bus.filter_size != '0) begin
              state_q <= S_FILTER;
            end else if (bus.row_len == '0 ||
                         bus.num_rows == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_IFMAP;
            end
          end
        end
        S_FILTER: begin
          if (f_end) begin
            if (no_ifmap) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_IFMAP;
            end
          end
        end
        S_IFMAP: begin
          if (i_end) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.filt_rd_en  = f_rd;
  assign bus.filt_addr   = faddr_q;
  assign bus.if_rd_en    = i_rd;
  assign bus.if_addr     = iaddr_q;
  assign bus.filter_wen  = f_wen;
  assign bus.filter_dout = f_valid ? f_dout : '0;
  assign bus.ifmap_wen   = i_wen;
  assign bus.ifmap_dout  = iword;

endmodule
